// File: rtl/apb_master_mslv_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_mslv_if
// Purpose  : Request/response and multi-slave APB signal bundle for apb_master_mslv.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_master_mslv_if #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 2
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [ADDR_W-1:0]         req_addr;
    logic [DATA_W-1:0]         req_wdata;
    logic                      rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      rsp_timeout;
    logic [NUM_SLV-1:0]        psel;
    logic                      penable;
    logic [ADDR_W-1:0]         paddr;
    logic                      pwrite;
    logic [DATA_W-1:0]         pwdata;
    logic [NUM_SLV-1:0]        pready;
    logic [NUM_SLV-1:0]        pslverr;
    logic [NUM_SLV*DATA_W-1:0] prdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, pready, pslverr, prdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, paddr, pwrite, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, pready, pslverr, prdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, paddr, pwrite, pwdata
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_mslv.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_mslv
// Purpose  : Parametrised multi-slave APB master behind a valid/ready request port.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_mslv #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 2,
    parameter int TIMEOUT = 16
) (
    input  wire logic         pclk,
    input  wire logic         presetn,
    apb_master_mslv_if.master bus
);
    localparam int SEL_W = $clog2(NUM_SLV);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [SEL_W:0]   C_NUM_SLV  = (SEL_W + 1)'(NUM_SLV);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              r_state, w_state;
    logic [SEL_W-1:0]    r_sel, w_sel;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic [NUM_SLV-1:0]  r_psel, w_psel;
    logic                r_penable, w_penable;
    logic [ADDR_W-1:0]   r_paddr, w_paddr;
    logic                r_pwrite, w_pwrite;
    logic [DATA_W-1:0]   r_pwdata, w_pwdata;
    logic                r_rsp_valid, w_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata;
    logic                r_rsp_err, w_rsp_err;
    logic                r_rsp_timeout, w_rsp_timeout;

    logic [SEL_W-1:0]    w_idx;
    logic                w_dec_ok;
    logic [DATA_W-1:0]   w_slv_rdata [NUM_SLV];

    // Decode from the incoming request, not from the previously latched paddr
    assign w_idx    = bus.req_addr[ADDR_W-1 -: SEL_W];
    assign w_dec_ok = ({1'b0, w_idx} < C_NUM_SLV);

    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
        assign w_slv_rdata[gi] = bus.prdata[gi*DATA_W +: DATA_W];
    end

    always_comb begin
        w_state       = r_state;
        w_sel         = r_sel;
        w_cnt         = r_cnt;
        w_psel        = r_psel;
        w_penable     = r_penable;
        w_paddr       = r_paddr;
        w_pwrite      = r_pwrite;
        w_pwdata      = r_pwdata;
        w_rsp_valid   = 1'b0;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_err     = r_rsp_err;
        w_rsp_timeout = r_rsp_timeout;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (w_dec_ok) begin
                        w_paddr   = bus.req_addr;
                        w_pwrite  = bus.req_write;
                        w_pwdata  = bus.req_wdata;
                        w_sel     = w_idx;
                        w_psel    = NUM_SLV'(1) << w_idx;
                        w_penable = 1'b0;
                        w_state   = ST_SETUP;
                    end else begin
                        w_rsp_valid   = 1'b1;
                        w_rsp_err     = 1'b1;
                        w_rsp_timeout = 1'b0;
                        w_rsp_rdata   = '0;
                    end
                end
            end
            ST_SETUP: begin
                w_penable = 1'b1;
                w_cnt     = '0;
                w_state   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready on the threshold cycle still completes normally
                if (bus.pready[r_sel]) begin
                    w_psel        = '0;
                    w_penable     = 1'b0;
                    w_state       = ST_IDLE;
                    w_rsp_valid   = 1'b1;
                    w_rsp_err     = bus.pslverr[r_sel];
                    w_rsp_timeout = 1'b0;
                    w_rsp_rdata   = (!r_pwrite && !bus.pslverr[r_sel]) ? w_slv_rdata[r_sel] : '0;
                end else if ((TIMEOUT > 0) && (r_cnt == C_CNT_LAST)) begin
                    w_psel        = '0;
                    w_penable     = 1'b0;
                    w_state       = ST_IDLE;
                    w_rsp_valid   = 1'b1;
                    w_rsp_err     = 1'b1;
                    w_rsp_timeout = 1'b1;
                    w_rsp_rdata   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state   = ST_IDLE;
                w_psel    = '0;
                w_penable = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state       <= ST_IDLE;
            r_sel         <= '0;
            r_cnt         <= '0;
            r_psel        <= '0;
            r_penable     <= 1'b0;
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_sel         <= w_sel;
            r_cnt         <= w_cnt;
            r_psel        <= w_psel;
            r_penable     <= w_penable;
            r_paddr       <= w_paddr;
            r_pwrite      <= w_pwrite;
            r_pwdata      <= w_pwdata;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_err     <= w_rsp_err;
            r_rsp_timeout <= w_rsp_timeout;
        end
    end

    assign bus.req_ready   = (r_state == ST_IDLE);
    assign bus.psel        = r_psel;
    assign bus.penable     = r_penable;
    assign bus.paddr       = r_paddr;
    assign bus.pwrite      = r_pwrite;
    assign bus.pwdata      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;
endmodule
`default_nettype wire

// File: tb/tb_apb_master_mslv.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_mslv
// Purpose  : Transaction-schedule reference model and per-cycle checker for apb_master_mslv.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_mslv;
    localparam int NSLV = 3;
    localparam int TO   = 4;
    localparam int MAXC = 4096;

    bit clk = 1'b0;
    bit presetn = 1'b0;
    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    apb_master_mslv_if #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(NSLV)) bus ();

    apb_master_mslv #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(NSLV), .TIMEOUT(TO)) dut (
        .pclk    (clk),
        .presetn (presetn),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle expectations, filled in whole when a request is accepted
    bit       exp_ready [MAXC];
    bit [2:0] exp_psel  [MAXC];
    bit       exp_pen   [MAXC];
    bit       exp_rsp   [MAXC];
    bit [7:0] e_rd      [MAXC];
    bit       e_err     [MAXC];
    bit       e_to      [MAXC];
    bit       new_apb   [MAXC];
    bit [8:0] n_addr    [MAXC];
    bit       n_wr      [MAXC];
    bit [7:0] n_wd      [MAXC];
    bit       rst_at    [MAXC];

    bit       active = 1'b0;
    int       cur_k, cur_e, cur_done, cur_idx;
    bit       cur_err;
    bit [7:0] cur_rd;
    int       nxt_w = 0;
    bit       nxt_err = 1'b0;
    bit [7:0] nxt_rd = 8'h00;
    bit       force_ff = 1'b0;
    bit       last_acc = 1'b0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic bit model_ready(int c);
        return !active || (c >= cur_e);
    endfunction

    task automatic set_rsp(int c, bit er, bit tmo, bit [7:0] rd);
        if (c < MAXC) begin
            exp_rsp[c] = 1'b1;
            e_err[c]   = er;
            e_to[c]    = tmo;
            e_rd[c]    = rd;
        end
    endtask

    task automatic model_reset(int c);
        for (int j = c; j < c + 16 && j < MAXC; j++) begin
            exp_ready[j] = 1'b1;
            exp_psel[j]  = 3'b000;
            exp_pen[j]   = 1'b0;
            exp_rsp[j]   = 1'b0;
            new_apb[j]   = 1'b0;
        end
        if (c < MAXC) rst_at[c] = 1'b1;
        active = 1'b0;
    endtask

    // Completion after w wait states lands in ACCESS cycle w+1, unless that exceeds TO
    task automatic schedule(int k, bit wr, bit [8:0] a, bit [7:0] wd);
        int idx, done, e;
        bit tmo;
        idx = int'(a[8:7]);
        if (idx >= NSLV) begin
            set_rsp(k + 1, 1'b1, 1'b0, 8'h00);
            active = 1'b0;
        end else begin
            tmo  = (nxt_w + 1 > TO);
            done = tmo ? -1 : k + 2 + nxt_w;
            e    = tmo ? k + 2 + TO : k + 3 + nxt_w;
            for (int j = k + 1; j < e && j < MAXC; j++) begin
                exp_ready[j] = 1'b0;
                exp_psel[j]  = 3'(1 << idx);
                exp_pen[j]   = (j >= k + 2);
            end
            if (k + 1 < MAXC) begin
                new_apb[k+1] = 1'b1;
                n_addr[k+1]  = a;
                n_wr[k+1]    = wr;
                n_wd[k+1]    = wd;
            end
            set_rsp(e, tmo | nxt_err, tmo, (tmo || nxt_err || wr) ? 8'h00 : nxt_rd);
            active   = 1'b1;
            cur_k    = k;
            cur_e    = e;
            cur_done = done;
            cur_idx  = idx;
            cur_err  = nxt_err;
            cur_rd   = nxt_rd;
        end
    endtask

    task automatic drive_slaves(int c);
        for (int i = 0; i < NSLV; i++) begin
            bus.pready[i]       = 1'($urandom_range(0, 1));
            bus.pslverr[i]      = 1'($urandom_range(0, 1));
            bus.prdata[i*8 +: 8] = 8'($urandom);
        end
        if (force_ff) bus.prdata[15:8] = 8'hFF;
        if (active && c >= cur_k + 2 && c < cur_e) begin
            bus.pready[cur_idx] = (c == cur_done);
            if (c == cur_done) begin
                bus.pslverr[cur_idx]       = cur_err;
                bus.prdata[cur_idx*8 +: 8] = cur_rd;
            end
        end
    endtask

    task automatic tick();
        int       c;
        bit       rst_edge, acc, wr;
        bit [8:0] a;
        bit [7:0] wd;
        c        = cyc;
        rst_edge = !presetn;
        acc      = presetn && bus.req_valid && model_ready(c);
        wr       = bus.req_write;
        a        = bus.req_addr;
        wd       = bus.req_wdata;
        @(posedge clk);
        #1;
        last_acc = acc;
        if (rst_edge) model_reset(c + 1);
        else if (acc) schedule(c, wr, a, wd);
        drive_slaves(c + 1);
    endtask

    task automatic send(bit wr, bit [8:0] a, bit [7:0] wd, int w, bit er, bit [7:0] rd);
        int guard;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        nxt_w   = w;
        nxt_err = er;
        nxt_rd  = rd;
        guard   = 0;
        do begin
            tick();
            guard++;
        end while (!last_acc && guard < 40);
        if (!last_acc) begin
            n_chk++;
            n_err++;
            $display("FAIL send_accept cycle %0d: got not-accepted expected accepted", cyc);
        end
    endtask

    // Compare process: every cycle, all outputs against the schedule
    initial begin
        bit [8:0] h_addr;
        bit       h_wr, h_err, h_to;
        bit [7:0] h_wd, h_rd;
        h_addr = '0; h_wr = 1'b0; h_wd = '0; h_rd = '0; h_err = 1'b0; h_to = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_on && cyc < MAXC) begin
                if (rst_at[cyc]) begin
                    h_addr = '0; h_wr = 1'b0; h_wd = '0; h_rd = '0; h_err = 1'b0; h_to = 1'b0;
                end
                if (new_apb[cyc]) begin
                    h_addr = n_addr[cyc]; h_wr = n_wr[cyc]; h_wd = n_wd[cyc];
                end
                if (exp_rsp[cyc]) begin
                    h_rd = e_rd[cyc]; h_err = e_err[cyc]; h_to = e_to[cyc];
                end
                check("req_ready",   bus.req_ready,   exp_ready[cyc]);
                check("psel",        bus.psel,        exp_psel[cyc]);
                check("penable",     bus.penable,     exp_pen[cyc]);
                check("rsp_valid",   bus.rsp_valid,   exp_rsp[cyc]);
                check("paddr",       bus.paddr,       h_addr);
                check("pwrite",      bus.pwrite,      h_wr);
                check("pwdata",      bus.pwdata,      h_wd);
                check("rsp_rdata",   bus.rsp_rdata,   h_rd);
                check("rsp_err",     bus.rsp_err,     h_err);
                check("rsp_timeout", bus.rsp_timeout, h_to);
            end
        end
    end

    initial begin
        for (int j = 0; j < MAXC; j++) exp_ready[j] = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        drive_slaves(0);
        tick();
        chk_on = 1'b1;
        tick();
        presetn = 1'b1;

        // Zero-wait write to slave 1
        send(1'b1, 9'h085, 8'hA5, 0, 1'b0, 8'h00);
        bus.req_valid = 1'b0;
        check("w0_setup_psel", bus.psel, 3'b010);
        check("w0_setup_pen", bus.penable, 1'b0);
        check("w0_pwdata", bus.pwdata, 8'hA5);
        tick();
        check("w0_access_pen", bus.penable, 1'b1);
        tick();
        check("w0_rsp_valid", bus.rsp_valid, 1'b1);
        check("w0_rsp_err", bus.rsp_err, 1'b0);

        // Read with two wait states; slave 1 drives 0xFF throughout
        force_ff = 1'b1;
        send(1'b0, 9'h010, 8'h00, 2, 1'b0, 8'h3C);
        bus.req_valid = 1'b0;
        repeat (3) tick();
        check("rd_access3_pen", bus.penable, 1'b1);
        tick();
        check("rd_rsp_valid", bus.rsp_valid, 1'b1);
        check("rd_rsp_rdata", bus.rsp_rdata, 8'h3C);
        force_ff = 1'b0;

        // Slave error on a write
        send(1'b1, 9'h020, 8'h11, 0, 1'b1, 8'h77);
        bus.req_valid = 1'b0;
        repeat (2) tick();
        check("se_rsp_err", bus.rsp_err, 1'b1);
        check("se_rsp_timeout", bus.rsp_timeout, 1'b0);
        check("se_rsp_rdata", bus.rsp_rdata, 8'h00);

        // Decode error: index 3 with three slaves
        send(1'b0, 9'h1C0, 8'h00, 0, 1'b0, 8'h00);
        bus.req_valid = 1'b0;
        check("de_rsp_valid", bus.rsp_valid, 1'b1);
        check("de_rsp_err", bus.rsp_err, 1'b1);
        check("de_psel", bus.psel, 3'b000);
        check("de_req_ready", bus.req_ready, 1'b1);

        // Timeout with pready held low
        send(1'b0, 9'h090, 8'h00, 9, 1'b0, 8'h5A);
        bus.req_valid = 1'b0;
        repeat (4) tick();
        check("to_access4_psel", bus.psel, 3'b010);
        tick();
        check("to_psel", bus.psel, 3'b000);
        check("to_pen", bus.penable, 1'b0);
        check("to_rsp_err", bus.rsp_err, 1'b1);
        check("to_rsp_timeout", bus.rsp_timeout, 1'b1);

        // pready in the fourth ACCESS cycle wins over the timeout
        send(1'b0, 9'h090, 8'h00, 3, 1'b0, 8'h5A);
        bus.req_valid = 1'b0;
        repeat (5) tick();
        check("tw_rsp_valid", bus.rsp_valid, 1'b1);
        check("tw_rsp_timeout", bus.rsp_timeout, 1'b0);
        check("tw_rsp_rdata", bus.rsp_rdata, 8'h5A);

        // Reset asserted during ACCESS
        send(1'b0, 9'h100, 8'h00, 9, 1'b0, 8'h00);
        bus.req_valid = 1'b0;
        tick();
        presetn = 1'b0;
        tick();
        check("rst_psel", bus.psel, 3'b000);
        check("rst_pen", bus.penable, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        presetn = 1'b1;
        tick();

        // Back-to-back: second request accepted in the first's response cycle
        send(1'b1, 9'h081, 8'hC3, 0, 1'b0, 8'h00);
        repeat (2) tick();
        check("b2b_rsp_valid", bus.rsp_valid, 1'b1);
        check("b2b_req_ready", bus.req_ready, 1'b1);
        send(1'b1, 9'h101, 8'h3C, 0, 1'b0, 8'h00);
        bus.req_valid = 1'b0;
        check("b2b_second_psel", bus.psel, 3'b100);
        check("b2b_second_paddr", bus.paddr, 9'h101);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 2000 && cyc < MAXC - 40; n++) begin
            presetn       = ($urandom_range(0, 199) != 0);
            bus.req_valid = ($urandom_range(0, 9) < 6);
            bus.req_write = 1'($urandom_range(0, 1));
            bus.req_addr  = 9'($urandom);
            bus.req_wdata = 8'($urandom);
            nxt_w         = $urandom_range(0, 6);
            nxt_err       = ($urandom_range(0, 3) == 0);
            nxt_rd        = 8'($urandom);
            tick();
        end

        presetn       = 1'b1;
        bus.req_valid = 1'b0;
        repeat (12) tick();
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire
